// File: rtl/bpsk_frame_loader_if.sv
// Payload byte stream feeding the BPSK frame loader (valid/ready/last).
interface bpsk_frame_loader_if #(
    parameter int data_width = 8
);
    logic [data_width-1:0] s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;

    // A beat transfers on a clock edge where s_valid && s_ready are both high; the
    // producer keeps s_data/s_last stable and s_valid high until that edge, and
    // s_ready may depend on loader state only (never on s_valid).
    modport master (output s_data, s_valid, s_last, input s_ready);
    modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/bpsk_frame_loader.sv
// Builds one BPSK frame in BRAM port A (preamble, fixed-length payload, CRC-8)
// and then holds send_signal high to start the phase controller.
module bpsk_frame_loader #(
    parameter int         data_width    = 8,
    parameter int         addr_width    = 8,
    parameter int         frame_length  = 150,
    parameter int         preamble_len  = 4,
    parameter logic [7:0] preamble_byte = 8'hAA,
    parameter int         hold_cycles   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    bpsk_frame_loader_if.slave      s,
    output logic                    ram_clk,
    output logic                    ram_rst,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic [addr_width-1:0]   ram_addr,
    output logic [data_width-1:0]   ram_wr_data,
    output logic                    send_signal,
    output logic                    err_overflow,
    output logic [15:0]             frame_count,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_PAYLOAD  = 3'd2,
        ST_PAD      = 3'd3,
        ST_DISCARD  = 3'd4,
        ST_CRC      = 3'd5,
        ST_SEND     = 3'd6
    } state_t;

    localparam int hold_w = $clog2(hold_cycles + 1);
    localparam logic [addr_width-1:0] last_pre_addr = addr_width'(preamble_len - 1);
    localparam logic [addr_width-1:0] last_pay_addr = addr_width'(frame_length - 2);
    localparam logic [addr_width-1:0] crc_addr      = addr_width'(frame_length - 1);
    localparam logic [hold_w-1:0]     last_hold     = hold_w'(hold_cycles - 1);

    state_t                  state_q, state_d;
    logic [addr_width-1:0]   addr_q, addr_d;
    logic [7:0]              crc_q, crc_d;
    logic [hold_w-1:0]       hold_q, hold_d;
    logic                    ram_en_q, ram_en_d;
    logic                    ram_we_q, ram_we_d;
    logic [addr_width-1:0]   ram_addr_q, ram_addr_d;
    logic [data_width-1:0]   ram_wr_data_q, ram_wr_data_d;
    logic                    send_q, send_d;
    logic                    err_q, err_d;
    logic [15:0]             frame_count_q, frame_count_d;
    logic                    s_ready_c;

    // CRC-8, polynomial 0x07, MSB first, one byte per call.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc ^ din;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        crc_d         = crc_q;
        hold_d        = hold_q;
        ram_en_d      = 1'b0;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        err_d         = 1'b0;
        frame_count_d = frame_count_q;
        s_ready_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s.s_valid) begin
                    state_d = ST_PREAMBLE;
                    addr_d  = '0;
                    crc_d   = 8'h00;
                end
            end
            ST_PREAMBLE: begin
                ram_en_d      = 1'b1;
                ram_we_d      = 1'b1;
                ram_addr_d    = addr_q;
                ram_wr_data_d = preamble_byte;
                addr_d        = addr_q + 1'b1;
                if (addr_q == last_pre_addr) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                s_ready_c = 1'b1;
                if (s.s_valid) begin
                    ram_en_d      = 1'b1;
                    ram_we_d      = 1'b1;
                    ram_addr_d    = addr_q;
                    ram_wr_data_d = s.s_data;
                    crc_d         = crc8_byte(crc_q, s.s_data);
                    addr_d        = addr_q + 1'b1;
                    // The final slot decides between a clean frame and an overflow.
                    if (addr_q == last_pay_addr) begin
                        state_d = s.s_last ? ST_CRC : ST_DISCARD;
                        err_d   = ~s.s_last;
                    end else if (s.s_last) begin
                        state_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                ram_en_d      = 1'b1;
                ram_we_d      = 1'b1;
                ram_addr_d    = addr_q;
                ram_wr_data_d = '0;
                crc_d         = crc8_byte(crc_q, 8'h00);
                addr_d        = addr_q + 1'b1;
                if (addr_q == last_pay_addr) begin
                    state_d = ST_CRC;
                end
            end
            ST_DISCARD: begin
                s_ready_c = 1'b1;
                if (s.s_valid && s.s_last) begin
                    state_d = ST_CRC;
                end
            end
            ST_CRC: begin
                ram_en_d      = 1'b1;
                ram_we_d      = 1'b1;
                ram_addr_d    = crc_addr;
                ram_wr_data_d = crc_q;
                hold_d        = '0;
                frame_count_d = frame_count_q + 16'd1;
                state_d       = ST_SEND;
            end
            ST_SEND: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == last_hold) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // send_signal is registered and therefore high exactly while in SEND.
        send_d = (state_d == ST_SEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            crc_q         <= 8'h00;
            hold_q        <= '0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
            send_q        <= 1'b0;
            err_q         <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            crc_q         <= crc_d;
            hold_q        <= hold_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            send_q        <= send_d;
            err_q         <= err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign s.s_ready    = s_ready_c;
    assign ram_clk      = clk;
    assign ram_rst      = 1'b0;
    assign ram_en       = ram_en_q;
    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wr_data  = ram_wr_data_q;
    assign send_signal  = send_q;
    assign err_overflow = err_q;
    assign frame_count  = frame_count_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_bpsk_frame_loader.sv
// Randomised and directed frames checked against a frame-image scoreboard.
module tb_bpsk_frame_loader;

    localparam int FL   = 14;
    localparam int PL   = 4;
    localparam int HOLD = 4;
    localparam int CAP  = FL - PL - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_clk, ram_rst, ram_en, ram_we;
    logic [7:0]  ram_addr, ram_wr_data;
    logic        send_signal, err_overflow;
    logic [15:0] frame_count;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    bpsk_frame_loader_if #(.data_width(8)) sif ();

    bpsk_frame_loader #(
        .data_width(8), .addr_width(8), .frame_length(FL), .preamble_len(PL),
        .preamble_byte(8'hAA), .hold_cycles(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .s(sif),
        .ram_clk(ram_clk), .ram_rst(ram_rst), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
        .send_signal(send_signal), .err_overflow(err_overflow),
        .frame_count(frame_count), .dbg_state(dbg_state)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  pay[$];
    logic [7:0]  msg_q[$];
    int          wr_cyc_q[$];

    int cyc = 0;
    int wr_cnt, send_hi, send_rises, send_rise_cyc, err_hi, bad_en, hs_cnt, to_cnt;
    logic send_prev = 1'b0;
    logic [15:0] exp_frames = 16'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: every BRAM write is matched in order against the expected image.
    always @(negedge clk) begin
        if (ram_en && ram_we) begin
            wr_cnt++;
            wr_cyc_q.push_back(cyc);
            if (exp_q.size() > 0) begin
                check_val("wr_addr_data", {16'd0, ram_addr, ram_wr_data}, {16'd0, exp_q.pop_front()});
            end
        end
        if (ram_en != ram_we) bad_en++;
        if (send_signal) send_hi++;
        if (send_signal && !send_prev) begin
            send_rises++;
            send_rise_cyc = cyc;
        end
        send_prev = send_signal;
        if (err_overflow) err_hi++;
        if (sif.s_valid && sif.s_ready) hs_cnt++;
    end

    // Reference CRC: bit-serial polynomial division of the whole message.
    function automatic logic [7:0] crc_ref();
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        foreach (msg_q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ msg_q[i][b];
                c = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    task automatic build_expected(input bit use_ovr, input logic [7:0] ovr);
        logic [7:0] b;
        exp_q.delete();
        msg_q.delete();
        for (int i = 0; i < PL; i++) exp_q.push_back({8'(i), 8'hAA});
        for (int i = 0; i < CAP; i++) begin
            b = (i < pay.size()) ? pay[i] : 8'h00;
            msg_q.push_back(b);
            exp_q.push_back({8'(PL + i), b});
        end
        exp_q.push_back({8'(FL - 1), use_ovr ? ovr : crc_ref()});
    endtask

    task automatic clear_monitor();
        wr_cnt = 0; send_hi = 0; send_rises = 0; err_hi = 0; bad_en = 0; hs_cnt = 0;
        to_cnt = 0;
        wr_cyc_q.delete();
    endtask

    task automatic drive_beat(input logic [7:0] d, input logic l);
        int n;
        bit hs;
        n = 0;
        hs = 1'b0;
        sif.s_data = d;
        sif.s_valid = 1'b1;
        sif.s_last = l;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = sif.s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) to_cnt++;
        sif.s_valid = 1'b0;
        sif.s_last = 1'b0;
    endtask

    task automatic run_frame(input int gap_min, input int gap_max, input bit chk_lat,
                             input bit use_ovr, input logic [7:0] ovr);
        int t0, n, g;
        n = pay.size();
        build_expected(use_ovr, ovr);
        clear_monitor();
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int i = 0; i < n; i++) begin
            drive_beat(pay[i], (i == n - 1) ? 1'b1 : 1'b0);
            if (i != n - 1) begin
                g = $urandom_range(gap_max, gap_min);
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        // Keep offering junk after the last beat: nothing more may be accepted.
        hs_cnt = 0;
        sif.s_valid = 1'b1;
        sif.s_data = 8'($urandom);
        sif.s_last = 1'b0;
        for (int k = 0; k < 200 && send_rises == 0; k++) @(negedge clk);
        sif.s_valid = 1'b0;
        for (int k = 0; k < 200 && send_signal; k++) @(negedge clk);
        @(negedge clk);
        exp_frames = exp_frames + 16'd1;

        check_val("accept_timeout", 32'(to_cnt), 32'd0);
        check_val("hs_after_last", 32'(hs_cnt), 32'd0);
        check_val("write_count", 32'(wr_cnt), 32'(FL));
        check_val("writes_missing", 32'(exp_q.size()), 32'd0);
        check_val("send_cycles", 32'(send_hi), 32'(HOLD));
        check_val("send_rises", 32'(send_rises), 32'd1);
        check_val("err_pulses", 32'(err_hi), (n > CAP) ? 32'd1 : 32'd0);
        check_val("frame_count", {16'd0, frame_count}, {16'd0, exp_frames});
        check_val("en_we_agree", 32'(bad_en), 32'd0);
        if (chk_lat) check_val("latency", 32'(send_rise_cyc - t0), 32'(1 + PL + CAP + 1));
        if (n < CAP && wr_cyc_q.size() == FL)
            check_val("pad_consecutive", 32'(wr_cyc_q[FL - 1] - wr_cyc_q[PL + n]), 32'(FL - 1 - PL - n));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_s_ready"}, 32'(sif.s_ready), 32'd0);
        check_val({tag, "_ram_en_we"}, {30'd0, ram_en, ram_we}, 32'd0);
        check_val({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check_val({tag, "_ram_wr_data"}, 32'(ram_wr_data), 32'd0);
        check_val({tag, "_send_err"}, {30'd0, send_signal, err_overflow}, 32'd0);
        check_val({tag, "_frame_count"}, 32'(frame_count), 32'd0);
        check_val({tag, "_ram_rst"}, 32'(ram_rst), 32'd0);
    endtask

    task automatic load_ascii();
        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
    endtask

    initial begin
        sif.s_data = 8'h00;
        sif.s_valid = 1'b0;
        sif.s_last = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // "123456789" back to back: known CRC-8 0xF4 and fixed latency.
        load_ascii();
        run_frame(0, 0, 1'b1, 1'b1, 8'hF4);

        // Short payload padded with zeros.
        pay.delete();
        pay.push_back(8'h01);
        pay.push_back(8'h02);
        run_frame(0, 0, 1'b0, 1'b0, 8'h00);

        // Overflow: 12 bytes into 9 slots.
        pay.delete();
        for (int i = 0; i < 12; i++) pay.push_back(8'h10 + 8'(i));
        run_frame(0, 0, 1'b0, 1'b0, 8'h00);

        // s_valid toggling every cycle must give the same image.
        load_ascii();
        run_frame(1, 1, 1'b0, 1'b1, 8'hF4);

        // Reset after three payload bytes abandons the frame.
        pay.delete();
        for (int i = 0; i < 3; i++) pay.push_back(8'($urandom));
        exp_q.delete();
        for (int i = 0; i < PL; i++) exp_q.push_back({8'(i), 8'hAA});
        for (int i = 0; i < 3; i++) exp_q.push_back({8'(PL + i), pay[i]});
        clear_monitor();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) drive_beat(pay[i], 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("abort");
        repeat (20) @(posedge clk);
        #1;
        check_val("abort_send", 32'(send_rises), 32'd0);
        check_val("abort_writes", 32'(wr_cnt), 32'd7);
        check_val("abort_missing", 32'(exp_q.size()), 32'd0);
        exp_frames = 16'd0;
        load_ascii();
        run_frame(0, 0, 1'b1, 1'b1, 8'hF4);

        // Random consecutive frames, lengths from 1 up to beyond capacity.
        for (int f = 0; f < 8; f++) begin
            int len;
            len = $urandom_range(CAP + 3, 1);
            pay.delete();
            for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
            run_frame(0, 2, 1'b0, 1'b0, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
